// File: rtl/mem_line_pkg.sv
// Shared types and width helpers for the line responder and its backing array.
package mem_line_pkg;

   typedef enum logic [2:0] {IDLE, LAT, RD, WR, DONE} state_t;

   // Counter width for n states; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int WORDS_PER_LINE_DEF = 4;
   localparam int DEPTH_WORDS_DEF    = 1024;
   localparam int LATENCY_DEF        = 3;

   localparam int OFFSET_W = cnt_w(WORDS_PER_LINE_DEF);
   localparam int INDEX_W  = cnt_w(DEPTH_WORDS_DEF);
   localparam int LAT_W    = cnt_w(LATENCY_DEF + 1);

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous word RAM; read data is registered and holds while en is low.
module mem_line_array
   import mem_line_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = cnt_w(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line refill / write-back responder with programmable access latency.
// Optional: CRITICAL_WORD_FIRST_EN starts read bursts at the requested word offset.
module mem_line_responder
   import mem_line_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter int DEPTH_WORDS    = DEPTH_WORDS_DEF,
   parameter int LATENCY        = LATENCY_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic              wr_done,
   output logic              busy
);

   localparam int OW = cnt_w(WORDS_PER_LINE);
   localparam int IW = cnt_w(DEPTH_WORDS);
   localparam int LW = cnt_w(LATENCY + 1);
   localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);
   localparam logic [LW-1:0] LAST_LAT  = LW'(LATENCY - 1);

   typedef struct packed {
      logic          write;
      logic [IW-1:0] index;
   } req_t;

   state_t        state, state_nx;
   req_t          req_q;
   logic [LW-1:0] lat_cnt;
   logic [OW-1:0] beat_cnt;
   logic          issued_all;
   // vld_pipe[0]: RAM read in flight, vld_pipe[1]: beat on the rd_* outputs
   logic [1:0]    vld_pipe;
   logic          last_s1;

   logic              accept, advance, issue, wr_fire, last_xfer;
   logic [OW-1:0]     start_off;
   logic [IW-1:0]     rd_addr, wr_addr, ram_addr;
   logic              ram_en, ram_we;
   logic [DATA_W-1:0] ram_rdata;

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_off = req_q.index[OW-1:0];
   logic unused_addr;
   assign unused_addr = ^{req_addr[ADDR_W-1:IW+2], req_addr[1:0]};
`else
   assign start_off = '0;
   logic unused_addr;
   assign unused_addr = ^{req_addr[ADDR_W-1:IW+2], req_addr[1:0], req_q.index[OW-1:0]};
`endif

   assign accept    = (state == IDLE) && req_valid;
   // The output stage can take a new beat when empty or when the current one leaves.
   assign advance   = !vld_pipe[1] || rd_ready;
   assign issue     = (state == RD) && !issued_all && advance;
   assign wr_fire   = (state == WR) && wr_valid;
   assign last_xfer = vld_pipe[1] && rd_ready && rd_last;

   assign rd_addr  = {req_q.index[IW-1:OW], OW'(start_off + beat_cnt)};
   assign wr_addr  = {req_q.index[IW-1:OW], beat_cnt};
   // Gating with rst_n keeps a beat presented on the reset edge out of the array.
   assign ram_en   = rst_n && (issue || wr_fire);
   assign ram_we   = wr_fire;
   assign ram_addr = wr_fire ? wr_addr : rd_addr;

   assign rd_valid = vld_pipe[1];

   mem_line_array #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (IW)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wr_data),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      wr_ready  = 1'b0;
      wr_done   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               if (LATENCY > 0)    state_nx = LAT;
               else if (req_write) state_nx = WR;
               else                state_nx = RD;
            end
         end
         LAT: if (lat_cnt == LAST_LAT) state_nx = req_q.write ? WR : RD;
         RD:  if (last_xfer) state_nx = IDLE;
         WR: begin
            wr_ready = 1'b1;
            if (wr_valid && (beat_cnt == LAST_BEAT)) state_nx = DONE;
         end
         DONE: begin
            wr_done  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_q      <= '0;
         lat_cnt    <= '0;
         beat_cnt   <= '0;
         issued_all <= 1'b0;
         vld_pipe   <= '0;
         last_s1    <= 1'b0;
         rd_data    <= '0;
         rd_last    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            req_q      <= '{write: req_write, index: req_addr[IW+1:2]};
            lat_cnt    <= '0;
            beat_cnt   <= '0;
            issued_all <= 1'b0;
         end
         if (state == LAT) lat_cnt <= lat_cnt + 1'b1;
         if (wr_fire) beat_cnt <= beat_cnt + 1'b1;
         if (issue) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) issued_all <= 1'b1;
         end
         // When stalled the RAM is not enabled, so its output holds the in-flight word.
         if (advance && (state == RD)) begin
            vld_pipe <= {vld_pipe[0], issue};
            last_s1  <= issue && (beat_cnt == LAST_BEAT);
            rd_last  <= vld_pipe[0] && last_s1;
            if (vld_pipe[0]) rd_data <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: directed cases then randomized traffic.
module tb_mem_line_responder;

   localparam int WPL   = 4;
   localparam int DEPTH = 1024;
   localparam int LATV  = 3;
   localparam int DW    = 32;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_write, req_ready;
   logic [AW-1:0] req_addr;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_last, rd_ready;
   logic [DW-1:0] rd_data;
   logic          wr_done, busy;

   always #5 clk = ~clk;

   mem_line_responder #(
      .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .DEPTH_WORDS(DEPTH), .LATENCY(LATV)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
      .wr_done(wr_done), .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: plain word array plus expected read-beat queue.
   logic [DW-1:0] ref_mem [DEPTH];
   bit            line_known [DEPTH/WPL];
   typedef struct { logic [DW-1:0] d; logic last; } beat_t;
   beat_t exp_q [$];
   int    exp_done  = 0;
   int    done_seen = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int widx(input logic [AW-1:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic void push_read(input logic [AW-1:0] a);
      int w, base, start;
      beat_t b;
      w    = widx(a);
      base = w - (w % WPL);
`ifdef CRITICAL_WORD_FIRST_EN
      start = w % WPL;
`else
      start = 0;
`endif
      for (int i = 0; i < WPL; i++) begin
         b.d    = ref_mem[base + ((start + i) % WPL)];
         b.last = (i == WPL - 1);
         exp_q.push_back(b);
      end
   endfunction

   // rd_ready driver: 0 = always ready, 1 = random, 3 = stall beat 1 for stall_left cycles
   int rr_mode    = 0;
   int stall_left = 0;
   int beat_idx   = 0;
   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            1: rd_ready = ($urandom % 4) != 0;
            3: begin
               if (rd_valid && beat_idx == 1 && stall_left > 0) begin
                  rd_ready = 1'b0;
                  stall_left--;
               end else rd_ready = 1'b1;
            end
            default: rd_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops on every transfer and checks hold behaviour while stalled.
   bit            first_seen = 0;
   int            first_cyc  = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   always @(negedge clk) begin
      if (!rst_n) prev_stall = 0;
      else begin
         if (prev_stall) begin
            check("stall_hold_valid", rd_valid, 1'b1);
            check("stall_hold_data", rd_data, prev_data);
            check("stall_hold_last", rd_last, prev_last);
         end
         if (rd_valid && !first_seen) begin
            first_seen = 1;
            first_cyc  = cyc;
         end
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("rd_unexpected_beat", 1'b1, 1'b0);
            else begin
               beat_t b;
               b = exp_q.pop_front();
               check("rd_data", rd_data, b.d);
               check("rd_last", rd_last, b.last);
            end
            beat_idx++;
         end
         if (wr_done) done_seen++;
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
         prev_last  = rd_last;
      end
   end

   // Present a request at posedge+1 and hold until accepted; returns the accepting cycle.
   task automatic issue_req(input logic [AW-1:0] a, input logic w, output int acc);
      bit ok;
      ok = 0;
      req_valid = 1'b1; req_write = w; req_addr = a;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk); #1;
      end
      acc = cyc;
      req_valid = 1'b0;
      if (!ok) check("req_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         ok = req_ready && (exp_q.size() == 0);
      end
      if (!ok) check(nm, 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WPL-1:0][DW-1:0] d,
                           input int abort_at, input bit gaps);
      int acc, i, base, guard;
      bit take;
      base = widx(a) - (widx(a) % WPL);
      issue_req(a, 1'b1, acc);
      i = 0; guard = 0;
      while (i < WPL && guard < 300) begin
         guard++;
         if (i == abort_at) begin
            rst_n = 1'b0; wr_valid = 1'b1; wr_data = d[i];
            @(negedge clk);
            check("abort_wr_ready_before", wr_ready, 1'b1);
            @(posedge clk); #1;
            rst_n = 1'b1; wr_valid = 1'b0;
            @(negedge clk);
            check("abort_req_ready", req_ready, 1'b1);
            check("abort_busy", busy, 1'b0);
            check("abort_wr_done", wr_done, 1'b0);
            check("abort_rd_valid", rd_valid, 1'b0);
            @(posedge clk); #1;
            repeat (6) @(posedge clk);
            #1;
            check("abort_no_done", done_seen, exp_done);
            line_known[base / WPL] = 1;
            return;
         end
         wr_valid = !(gaps && ($urandom % 3 == 0));
         wr_data  = d[i];
         @(negedge clk);
         take = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (take) begin
            ref_mem[base + i] = d[i];
            i++;
         end
      end
      wr_valid = 1'b0;
      if (i < WPL) check("wr_beat_timeout", 1'b0, 1'b1);
      exp_done++;
      wait_idle("wr_idle_timeout");
      check("wr_done_count", done_seen, exp_done);
      line_known[base / WPL] = 1;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input bit chk_lat, input bit poke);
      int acc;
      bit seen;
      first_seen = 0;
      beat_idx   = 0;
      push_read(a);
      issue_req(a, 1'b0, acc);
      if (poke) begin
         // Requests offered while busy must be refused and dropped.
         req_addr = 32'h200; req_write = 1'b1; req_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
         end
         req_valid = 1'b0;
         seen = 0;
         for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = first_seen;
         end
         if (seen && exp_q.size() > 1) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            @(negedge clk);
            check("rd_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
      end
      wait_idle("rd_idle_timeout");
      if (chk_lat) check("rd_latency", first_cyc - acc, LATV + 2);
      if (poke) begin
         repeat (4) @(posedge clk);
         #1;
         check("poke_no_done", done_seen, exp_done);
      end
   endtask

   logic [WPL-1:0][DW-1:0] line_d;

   task automatic fill(input logic [DW-1:0] b);
      for (int i = 0; i < WPL; i++) line_d[i] = b + DW'(i);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = '0;
      wr_valid = 0; wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_last", rd_last, 1'b0);
      check("rst_rd_data", rd_data, '0);
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_wr_done", wr_done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      fill(32'hA0); do_write(32'h40, line_d, -1, 0);
      do_read(32'h40, 1, 0);

      rr_mode = 3; stall_left = 3;
      do_read(32'h40, 1, 0);
      check("stall_consumed", stall_left, 0);
      rr_mode = 0;

      do_read(32'h40, 1, 1);

      fill(32'hB0); do_write(32'h80, line_d, -1, 0);
      fill(32'hC0); do_write(32'h80, line_d, 2, 0);
      do_read(32'h80, 1, 0);

      fill(32'hD0); do_write(32'h40 + DEPTH * 4, line_d, -1, 1);
      do_read(32'h40, 1, 0);

      fill(32'hA0); do_write(32'h40, line_d, -1, 0);
      do_read(32'h4B, 1, 0);

      rr_mode = 1;
      for (int t = 0; t < 40; t++) begin
         logic [AW-1:0] a;
         int ln;
         ln = $urandom_range(0, 15);
         a  = AW'(ln * WPL * 4) | AW'($urandom_range(0, WPL - 1) << 2) | AW'($urandom_range(0, 3))
              | AW'($urandom_range(0, 3) * DEPTH * 4);
         if (!line_known[widx(a) / WPL] || ($urandom % 2 == 0)) begin
            for (int i = 0; i < WPL; i++) line_d[i] = $urandom;
            do_write(a, line_d, -1, 1);
         end else do_read(a, 0, 0);
      end
      rr_mode = 0;
      repeat (5) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      check("final_done_count", done_seen, exp_done);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1);
   end

endmodule
